// File: rtl/fir_pkg.sv
// Q-format constants shared by the FIR output path and its requantizer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fir_pkg;

  // Raw FIR accumulator output format (signed Q32 in 35 bits)
  localparam int FIR_OUT_WIDTH = 35;
  localparam int FIR_OUT_FRAC  = 32;

  // Sample format handed to the DAC / packetiser (signed Q15)
  localparam int SAMPLE_WIDTH  = 16;
  localparam int SAMPLE_FRAC   = 15;

  // Number of fractional bits dropped going from FIR output to sample
  localparam int SH = FIR_OUT_FRAC - SAMPLE_FRAC;

  // Rounded intermediate carries one extra bit so +1 rounding cannot overflow
  localparam int RND_WIDTH = FIR_OUT_WIDTH - SH + 1;

endpackage

// File: rtl/fir_output_requantizer_if.sv
// Sample stream bundle: data plus valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: transfer happens when valid & ready on a clock edge.
// Ports: data (signed, WIDTH bits), valid (master->slave), ready (slave->master).
interface fir_output_requantizer_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] data;
  logic                    valid;
  logic                    ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/fir_round_half_even.sv
// Drops SH fractional bits from a signed value with round-half-to-even.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; caller owns any pipelining.
// Ports: i_data (signed IN_WIDTH), o_rnd (signed IN_WIDTH-SH+1, never overflows).
module fir_round_half_even #(
  parameter int IN_WIDTH = 35,
  parameter int SH       = 17
) (
  input  logic signed [IN_WIDTH-1:0] i_data,
  output logic signed [IN_WIDTH-SH:0] o_rnd
);

  logic [IN_WIDTH-SH-1:0] w_t;
  logic                   w_lsb;
  logic                   w_guard;
  logic                   w_sticky;
  logic                   w_round_up;

  // Upper bits are the floor of the value in the coarser format
  assign w_t      = i_data[IN_WIDTH-1:SH];
  assign w_lsb    = i_data[SH];
  assign w_guard  = i_data[SH-1];
  assign w_sticky = |i_data[SH-2:0];

  // Above half always rounds up; exactly half rounds up only from an odd floor.
  // Working on the floor makes this correct for negative inputs too.
  assign w_round_up = w_guard & (w_sticky | w_lsb);

  assign o_rnd = $signed({w_t[IN_WIDTH-SH-1], w_t})
               + $signed({{(IN_WIDTH-SH){1'b0}}, w_round_up});

endmodule

// File: rtl/fir_output_requantizer.sv
// FIR Q32 result -> Q15 sample: round-half-even, saturate, count clipped samples.
// Latency: 2 cycles from input acceptance to o_out.valid; 1 sample/cycle throughput.
// Backpressure: both stages stall together when output is valid and not ready;
//   i_in.ready = !o_out.valid | o_out.ready (combinational).
// Ports: clk, reset (sync, active-high), i_in (slave stream, IN_WIDTH),
//   o_out (master stream, OUT_WIDTH), clear_stats (pulse), sat_count, sat_flag.
module fir_output_requantizer
  import fir_pkg::*;
#(
  parameter int IN_WIDTH      = FIR_OUT_WIDTH,
  parameter int IN_FRAC       = FIR_OUT_FRAC,
  parameter int OUT_WIDTH     = SAMPLE_WIDTH,
  parameter int OUT_FRAC      = SAMPLE_FRAC,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  fir_output_requantizer_if.slave   i_in,
  fir_output_requantizer_if.master  o_out,
  input  logic                      clear_stats,
  output logic [SAT_CNT_WIDTH-1:0]  sat_count,
  output logic                      sat_flag
);

  localparam int LSH = IN_FRAC - OUT_FRAC;
  localparam int RW  = IN_WIDTH - LSH + 1;

  localparam logic signed [RW-1:0] C_MAX = RW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] C_MIN = RW'(-(2 ** (OUT_WIDTH - 1)));

  logic                          w_advance;
  logic signed [RW-1:0]          w_rnd;
  logic signed [OUT_WIDTH-1:0]   w_sat_dat;
  logic                          w_sat;
  logic                          w_sat_evt;

  logic                          r_s1_vld;
  logic signed [RW-1:0]          r_s1_rnd;
  logic                          r_out_valid;
  logic signed [OUT_WIDTH-1:0]   r_out_data;
  logic [SAT_CNT_WIDTH-1:0]      r_sat_count;
  logic                          r_sat_flag;

  // Single stall signal for the whole pipe: it moves only if the output slot frees up
  assign w_advance  = !r_out_valid | o_out.ready;
  assign i_in.ready = w_advance;

  fir_round_half_even #(
    .IN_WIDTH (IN_WIDTH),
    .SH       (LSH)
  ) u_round (
    .i_data (i_in.data),
    .o_rnd  (w_rnd)
  );

  // Clamp is judged after rounding, so a value that rounds past full scale clips
  always_comb begin
    w_sat     = 1'b0;
    w_sat_dat = r_s1_rnd[OUT_WIDTH-1:0];
    if (r_s1_rnd > C_MAX) begin
      w_sat     = 1'b1;
      w_sat_dat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (r_s1_rnd < C_MIN) begin
      w_sat     = 1'b1;
      w_sat_dat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  // A clip is recorded at the moment its sample moves into the output register
  assign w_sat_evt = w_advance & r_s1_vld & w_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld    <= 1'b0;
      r_s1_rnd    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_s1_vld    <= i_in.valid;
      if (i_in.valid) begin
        r_s1_rnd  <= w_rnd;
      end
      r_out_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_data <= w_sat_dat;
      end
    end
  end

  // Clear wins over a same-cycle clip; the counter pins at all-ones
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      r_sat_count <= '0;
      r_sat_flag  <= 1'b0;
    end else if (w_sat_evt) begin
      r_sat_flag <= 1'b1;
      if (r_sat_count != '1) begin
        r_sat_count <= r_sat_count + SAT_CNT_WIDTH'(1);
      end
    end
  end

  assign o_out.data  = r_out_data;
  assign o_out.valid = r_out_valid;
  assign sat_count   = r_sat_count;
  assign sat_flag    = r_sat_flag;

endmodule

// File: tb/tb_fir_output_requantizer.sv
module tb_fir_output_requantizer;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        clr3;
  logic [15:0] sat_count;
  logic        sat_flag;
  logic [2:0]  sat_count3;
  logic        sat_flag3;

  int n_checks;
  int n_fail;

  fir_output_requantizer_if #(.WIDTH(35)) in_if ();
  fir_output_requantizer_if #(.WIDTH(16)) out_if ();
  fir_output_requantizer_if #(.WIDTH(35)) in3_if ();
  fir_output_requantizer_if #(.WIDTH(16)) out3_if ();

  fir_output_requantizer u_dut (
    .clk         (clk),
    .reset       (reset),
    .i_in        (in_if),
    .o_out       (out_if),
    .clear_stats (clr),
    .sat_count   (sat_count),
    .sat_flag    (sat_flag)
  );

  fir_output_requantizer #(.SAT_CNT_WIDTH(3)) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .i_in        (in3_if),
    .o_out       (out3_if),
    .clear_stats (clr3),
    .sat_count   (sat_count3),
    .sat_flag    (sat_flag3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
    $fatal(1, "watchdog");
  end

  // Reference: exact rational rounding of x / 2^17, ties to even, then clamp to Q15
  function automatic void ref_model(input longint x, output int y, output bit clip);
    longint d;
    longint rem;
    longint fl;
    longint q;
    d   = 64'sd131072;
    rem = ((x % d) + d) % d;
    fl  = (x - rem) / d;
    if (rem > d / 2 || (rem == d / 2 && (fl % 2) != 0)) q = fl + 1;
    else q = fl;
    clip = 1'b0;
    if (q > 32767)       begin q = 32767;  clip = 1'b1; end
    else if (q < -32768) begin q = -32768; clip = 1'b1; end
    y = int'(q);
  endfunction

  function automatic longint gen_sample();
    longint x;
    longint offs;
    int     mode;
    mode = $urandom_range(0, 3);
    case ($urandom_range(0, 4))
      0: offs = 0;
      1: offs = 65536;
      2: offs = 65535;
      3: offs = 65537;
      default: offs = 131071;
    endcase
    if (mode == 0) begin
      x = {$urandom(), $urandom()};
      x = (x <<< 29) >>> 29;
    end else if (mode == 3) begin
      x = (longint'($urandom_range(0, 4)) + 32765) * 131072 + offs;
      if ($urandom_range(0, 1) == 1) x = -x;
    end else begin
      x = (longint'($urandom_range(0, 80000)) - 40000) * 131072 + offs;
    end
    return x;
  endfunction

  // Drives one sample into the idle main DUT and reports what the output showed
  // one and two cycles after acceptance.
  task automatic send_single(input longint x, output logic v_early, output logic v,
                             output logic [15:0] d);
    @(posedge clk); #1;
    in_if.valid  = 1'b1;
    in_if.data   = x[34:0];
    out_if.ready = 1'b1;
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    @(negedge clk);
    v_early = out_if.valid;
    @(negedge clk);
    v = out_if.valid;
    d = out_if.data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_if.valid); end
    if (out_if.data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_if.data); end
    if (sat_count !== 16'h0)   begin n_fail++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
    if (sat_flag !== 1'b0)     begin n_fail++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
    if (out3_if.valid !== 1'b0 || sat_count3 !== 3'd0) begin
      n_fail++; $display("FAIL reset_dut3 got valid=%b cnt=%0d exp valid=0 cnt=0", out3_if.valid, sat_count3);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_ties();
    longint      vin [4];
    logic [15:0] vexp [4];
    logic        ve, v;
    logic [15:0] d;
    vin[0] = 64'sh1_0000;  vexp[0] = 16'd0;
    vin[1] = 64'sh3_0000;  vexp[1] = 16'd2;
    vin[2] = -64'sd65536;  vexp[2] = 16'd0;
    vin[3] = 64'sh1_0001;  vexp[3] = 16'd1;
    for (int i = 0; i < 4; i++) begin
      send_single(vin[i], ve, v, d);
      n_checks += 2;
      if (ve !== 1'b0 || v !== 1'b1) begin
        n_fail++; $display("FAIL ties_latency[%0d] got valid@1=%b valid@2=%b exp 0,1", i, ve, v);
      end
      if (d !== vexp[i]) begin
        n_fail++; $display("FAIL ties_data[%0d] got=%h exp=%h", i, d, vexp[i]);
      end
    end
  endtask

  task automatic test_limits();
    longint      vin [4];
    logic [15:0] vexp [4];
    logic        ve, v;
    logic [15:0] d;
    vin[0] = 64'sd2147483648;   vexp[0] = 16'h4000;
    vin[1] = -64'sd4294967296;  vexp[1] = 16'h8000;
    vin[2] = 64'sd4294967296;   vexp[2] = 16'h7FFF;
    vin[3] = -64'sd17179869184; vexp[3] = 16'h8000;
    for (int i = 0; i < 4; i++) begin
      send_single(vin[i], ve, v, d);
      n_checks++;
      if (v !== 1'b1 || d !== vexp[i]) begin
        n_fail++; $display("FAIL limits_data[%0d] got valid=%b data=%h exp valid=1 data=%h", i, v, d, vexp[i]);
      end
      if (i == 1) begin
        n_checks++;
        if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin
          n_fail++; $display("FAIL limits_noclip got cnt=%0d flag=%b exp cnt=0 flag=0", sat_count, sat_flag);
        end
      end
    end
    n_checks++;
    if (sat_count !== 16'd2 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL limits_clip got cnt=%0d flag=%b exp cnt=2 flag=1", sat_count, sat_flag);
    end
  endtask

  task automatic test_backpressure();
    int          idx;
    int          nout;
    logic [15:0] held;
    logic [15:0] outs [8];
    longint      t;
    idx  = 0;
    nout = 0;
    held = '0;
    for (int c = 0; c < 80 && nout < 8; c++) begin
      @(posedge clk); #1;
      t = longint'(idx + 1) * 131072;
      in_if.valid  = (idx < 8);
      in_if.data   = t[34:0];
      out_if.ready = !(c >= 3 && c <= 7);
      @(negedge clk);
      if (c == 3) held = out_if.data;
      if (c >= 3 && c <= 7) begin
        n_checks += 2;
        if (in_if.ready !== 1'b0 || out_if.valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_stall[%0d] got in_ready=%b out_valid=%b exp 0,1", c, in_if.ready, out_if.valid);
        end
        if (c > 3 && out_if.data !== held) begin
          n_fail++; $display("FAIL bp_hold[%0d] got=%h exp=%h", c, out_if.data, held);
        end
      end
      if (in_if.valid && in_if.ready) idx++;
      if (out_if.valid && out_if.ready) begin
        outs[nout] = out_if.data;
        nout++;
      end
    end
    @(posedge clk); #1;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    n_checks++;
    if (nout != 8) begin
      n_fail++; $display("FAIL bp_count got=%0d exp=8", nout);
    end
    for (int i = 0; i < nout; i++) begin
      n_checks++;
      if (outs[i] !== 16'(i + 1)) begin
        n_fail++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, outs[i], i + 1);
      end
    end
  endtask

  task automatic test_ceiling();
    longint t;
    t = 64'sd4294967296;
    out3_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in3_if.valid = 1'b1;
      in3_if.data  = t[34:0];
    end
    @(posedge clk); #1;
    in3_if.valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sat_count3 !== 3'd7 || sat_flag3 !== 1'b1) begin
      n_fail++; $display("FAIL ceil_count got cnt=%0d flag=%b exp cnt=7 flag=1", sat_count3, sat_flag3);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sat_count3 !== 3'd7) begin
      n_fail++; $display("FAIL ceil_hold got=%0d exp=7", sat_count3);
    end
    // 11th clip: clear pulse lines up with its move into the output register
    @(posedge clk); #1;
    in3_if.valid = 1'b1;
    in3_if.data  = t[34:0];
    @(posedge clk); #1;
    in3_if.valid = 1'b0;
    clr3 = 1'b1;
    @(posedge clk); #1;
    clr3 = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (sat_count3 !== 3'd0 || sat_flag3 !== 1'b0) begin
      n_fail++; $display("FAIL ceil_clear got cnt=%0d flag=%b exp cnt=0 flag=0", sat_count3, sat_flag3);
    end
    if (out3_if.valid !== 1'b1 || out3_if.data !== 16'h7FFF) begin
      n_fail++; $display("FAIL ceil_clear_data got valid=%b data=%h exp valid=1 data=7fff", out3_if.valid, out3_if.data);
    end
    @(posedge clk); #1;
    in3_if.valid = 1'b1;
    in3_if.data  = t[34:0];
    @(posedge clk); #1;
    in3_if.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sat_count3 !== 3'd1 || sat_flag3 !== 1'b1) begin
      n_fail++; $display("FAIL ceil_after_clear got cnt=%0d flag=%b exp cnt=1 flag=1", sat_count3, sat_flag3);
    end
  endtask

  task automatic test_reset_mid();
    longint      t;
    logic        ve, v;
    logic [15:0] d;
    out_if.ready = 1'b0;
    @(posedge clk); #1;
    t = 64'sd4294967296;
    in_if.valid = 1'b1;
    in_if.data  = t[34:0];
    @(posedge clk); #1;
    t = 64'sd131072;
    in_if.data = t[34:0];
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_if.valid !== 1'b1 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre got valid=%b flag=%b exp valid=1 flag=1", out_if.valid, sat_flag);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    out_if.ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", out_if.valid); end
    if (sat_count !== 16'd0)   begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", sat_count); end
    if (sat_flag !== 1'b0)     begin n_fail++; $display("FAIL midrst_flag got=%b exp=0", sat_flag); end
    send_single(64'sd131072, ve, v, d);
    n_checks++;
    if (ve !== 1'b0 || v !== 1'b1 || d !== 16'd1) begin
      n_fail++; $display("FAIL midrst_post got valid@1=%b valid@2=%b data=%h exp 0,1,0001", ve, v, d);
    end
  endtask

  task automatic test_random();
    int     expq [$];
    int     sent;
    int     clips;
    int     y;
    int     e;
    bit     c;
    bit     pending;
    longint cur;
    int     cyc;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL rand_clear got cnt=%0d flag=%b exp 0,0", sat_count, sat_flag);
    end
    sent    = 0;
    clips   = 0;
    pending = 1'b0;
    cur     = 0;
    cyc     = 0;
    while (cyc < 60000 && (sent < 10000 || expq.size() != 0)) begin
      @(posedge clk); #1;
      if (!pending && sent < 10000 && $urandom_range(0, 3) != 0) begin
        cur     = gen_sample();
        pending = 1'b1;
      end
      in_if.valid  = pending;
      in_if.data   = cur[34:0];
      out_if.ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_if.valid && out_if.ready) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL rand_extra got data=%h exp no output", out_if.data);
        end else begin
          e = expq.pop_front();
          if (out_if.data !== 16'(e)) begin
            n_fail++; $display("FAIL rand_data got=%h exp=%h", out_if.data, 16'(e));
          end
        end
      end
      if (in_if.valid && in_if.ready) begin
        ref_model(cur, y, c);
        expq.push_back(y);
        if (c) clips++;
        sent++;
        pending = 1'b0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 3;
    if (expq.size() != 0 || sent != 10000) begin
      n_fail++; $display("FAIL rand_drain got pending=%0d sent=%0d exp pending=0 sent=10000", expq.size(), sent);
    end
    if (out_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL rand_idle got valid=%b exp=0", out_if.valid);
    end
    if (sat_count !== 16'(clips) || sat_flag !== (clips != 0)) begin
      n_fail++; $display("FAIL rand_stats got cnt=%0d flag=%b exp cnt=%0d flag=%b", sat_count, sat_flag, clips, clips != 0);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    clr           = 1'b0;
    clr3          = 1'b0;
    in_if.valid   = 1'b0;
    in_if.data    = '0;
    out_if.ready  = 1'b1;
    in3_if.valid  = 1'b0;
    in3_if.data   = '0;
    out3_if.ready = 1'b1;
    test_reset();
    test_ties();
    test_limits();
    test_backpressure();
    test_ceiling();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_output_requantizer.md
Name: fir_output_requantizer

Overview:
- Sits directly downstream of the 101-tap FIR filter.
- Converts the filter's 35-bit Q32 result to a 16-bit Q15 sample using round-half-to-even, then saturates to the Q15 range.
- 2-stage pipeline with valid/ready flow control toward the DAC/packetiser.
- Keeps a saturating count of clipped samples plus a sticky clip flag for software.

Parameters:
IN_WIDTH, 35, input sample width (signed)
IN_FRAC, 32, input fractional bits
OUT_WIDTH, 16, output sample width (signed)
OUT_FRAC, 15, output fractional bits
SAT_CNT_WIDTH, 16, width of the clip counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
in_data  in  IN_WIDTH  signed Q32 sample from the filter
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  OUT_WIDTH  signed Q15 rounded/saturated sample
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts out_data
clear_stats  in  1  one-cycle pulse; clears sat_count and sat_flag
sat_count  out  SAT_CNT_WIDTH  number of clipped samples, sticks at all-ones
sat_flag  out  1  sticky; set on any clip since last clear/reset

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, sat_count=0, sat_flag=0, internal valid bits=0.
- A reset asserted mid-stream discards all in-flight samples; no output handshake occurs in that cycle.

Flow control:
- advance = !out_valid | out_ready.
- in_ready = advance. This is combinational from out_ready and out_valid.
- An input is accepted when in_valid & in_ready.
- When advance=0, both stages hold. out_data and out_valid stay stable until consumed.
- Latency is 2 cycles from acceptance to out_valid with no stall. Throughput is 1 sample/cycle.

Stage 1 (round), registered:
- SH = IN_FRAC-OUT_FRAC (17). t = in_data >>> SH, arithmetic, IN_WIDTH-SH bits (18).
- lsb = in_data[SH]; guard = in_data[SH-1]; sticky = |in_data[SH-2:0].
- round_up = guard & (sticky | lsb). This is half-to-even for both signs.
- r = sign-extended t + round_up, width IN_WIDTH-SH+1 (19), so it never overflows.

Stage 2 (saturate), registered:
- If r > 2^(OUT_WIDTH-1)-1 then out_data = 0x7FFF, sat=1.
- Else if r < -2^(OUT_WIDTH-1) then out_data = 0x8000, sat=1.
- Else out_data = r[OUT_WIDTH-1:0], sat=0.
- Saturation is judged on the value after rounding, so 32767.5 LSB rounds to 32768 and clips.

Stats, updated when a sample enters stage 2 with sat=1:
- sat_count increments and holds at 2^SAT_CNT_WIDTH-1 with no wrap.
- sat_flag sets.
- clear_stats has priority over a simultaneous increment: result is count=0, flag=0, and that clip is not counted.
- clear_stats has no effect on the data path.

Decomposition:
- Shared package fir_pkg holds:
  - Q-format constants (FIR_OUT_WIDTH=35, FIR_OUT_FRAC=32, SAMPLE_WIDTH=16, SAMPLE_FRAC=15).
  - Derived SH.
  - Rounded-intermediate width.
- One natural sub-module: fir_round_half_even, purely combinational. It takes in_data and produces r. It is reusable by other Q-conversion points.
- Saturation and pipeline control stay in the top module.

Test Plan:
- Ties, out_ready=1, single samples:
  - in=0x0_0001_0000 (0.5 LSB) -> out=0.
  - in=0x0_0003_0000 (1.5 LSB) -> out=2.
  - in=-65536 (-0.5 LSB) -> out=0.
  - in=0x0_0001_0001 -> out=1.
  - Each appears exactly 2 cycles after acceptance.
- Range limits:
  - in=2^31 -> 0x4000, no clip.
  - in=-2^32 -> 0x8000, no clip, sat_count stays 0.
  - in=2^32 -> 0x7FFF, clip.
  - in=-2^34 -> 0x8000, clip. sat_count=2 and sat_flag=1 after these two.
- Backpressure:
  - Stream 1..8 (as 1<<17 multiples).
  - Drop out_ready for 5 cycles while out_valid=1: out_data is held and in_ready=0.
  - Resume: outputs are 1..8 in order, none lost or duplicated.
- Counter ceiling, with SAT_CNT_WIDTH=3:
  - Send 10 clipping samples -> sat_count=7 and stays at 7.
  - Pulse clear_stats in the same cycle as an 11th clip -> count=0, flag=0.
- Reset mid-stream:
  - Assert reset with both stages full -> next cycle out_valid=0, sat_count=0, sat_flag=0.
  - Post-reset sample 1<<17 -> out=1 after 2 cycles.
- Random regression:
  - 10k random in_data with random out_ready.
  - Compare against a reference model: round-half-even, then clamp to Q15.
  - Ordering and sat_count must match.
